// File: rtl/int_branch_recovery_arbiter.sv
// Picks the oldest mispredicted branch across integer lanes and hands it to
// the recovery manager, parking one older mispredict while recovery runs.
module int_branch_recovery_arbiter #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PTR_WIDTH   = 6,
  parameter int PC_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ISSUE_WIDTH-1:0]          brValid,
  input  logic [ISSUE_WIDTH-1:0]          brMispred,
  input  logic [ISSUE_WIDTH*PTR_WIDTH-1:0] brPtr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] brNextAddr,
  input  logic [PTR_WIDTH-1:0]            alHeadPtr,
  input  logic                            recAck,
  input  logic                            recDone,
  output logic                            recReq,
  output logic [PTR_WIDTH-1:0]            recPtr,
  output logic [PC_WIDTH-1:0]             recAddr,
  output logic                            busy,
  output logic [15:0]                     dropCnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state, stateNxt;
  logic [PTR_WIDTH-1:0] heldPtr, heldPtrNxt;
  logic [PC_WIDTH-1:0]  heldAddr, heldAddrNxt;
  logic [PTR_WIDTH-1:0] flightPtr, flightPtrNxt;
  logic                 pendValid, pendValidNxt;
  logic [PTR_WIDTH-1:0] pendPtr, pendPtrNxt;
  logic [PC_WIDTH-1:0]  pendAddr, pendAddrNxt;
  logic [15:0]          dropCntNxt;

  logic                 anyQual;
  logic [7:0]           nQual;
  logic [7:0]           dropInc;
  logic [PTR_WIDTH-1:0] winPtr;
  logic [PC_WIDTH-1:0]  winAddr;
  logic [PTR_WIDTH-1:0] winAge;
  logic [PTR_WIDTH-1:0] refPtr;
  logic                 doWait;
  logic [16:0]          dropSum;

  function automatic logic older(
    input logic [PTR_WIDTH-1:0] a,
    input logic [PTR_WIDTH-1:0] b,
    input logic [PTR_WIDTH-1:0] head
  );
    logic [PTR_WIDTH-1:0] ageA;
    logic [PTR_WIDTH-1:0] ageB;
    ageA = a - head;
    ageB = b - head;
    return ageA < ageB;
  endfunction

  // Oldest qualifying lane; strict compare keeps the lowest index on ties
  always_comb begin
    anyQual = 1'b0;
    nQual   = '0;
    winPtr  = '0;
    winAddr = '0;
    winAge  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (brValid[i] && brMispred[i]) begin
        nQual = nQual + 8'd1;
        if (!anyQual ||
            (brPtr[i*PTR_WIDTH +: PTR_WIDTH] - alHeadPtr) < winAge) begin
          winPtr  = brPtr[i*PTR_WIDTH +: PTR_WIDTH];
          winAddr = brNextAddr[i*PC_WIDTH +: PC_WIDTH];
          winAge  = brPtr[i*PTR_WIDTH +: PTR_WIDTH] - alHeadPtr;
        end
        anyQual = 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt     = state;
    heldPtrNxt   = heldPtr;
    heldAddrNxt  = heldAddr;
    flightPtrNxt = flightPtr;
    pendValidNxt = pendValid;
    pendPtrNxt   = pendPtr;
    pendAddrNxt  = pendAddr;
    dropInc      = anyQual ? nQual - 8'd1 : 8'd0;
    refPtr       = (state == REQ) ? heldPtr : flightPtr;
    doWait       = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyQual) begin
          heldPtrNxt  = winPtr;
          heldAddrNxt = winAddr;
          stateNxt    = REQ;
        end
      end
      REQ: begin
        if (recAck) begin
          stateNxt     = WAIT;
          flightPtrNxt = heldPtr;
          doWait       = 1'b1;
        end else if (anyQual) begin
          if (older(winPtr, heldPtr, alHeadPtr)) begin
            heldPtrNxt  = winPtr;
            heldAddrNxt = winAddr;
          end else begin
            dropInc = nQual;
          end
        end
      end
      WAIT: begin
        if (recDone) begin
          pendValidNxt = 1'b0;
          stateNxt     = REQ;
          if (pendValid && anyQual) begin
            dropInc = nQual;
            if (older(winPtr, pendPtr, alHeadPtr)) begin
              heldPtrNxt  = winPtr;
              heldAddrNxt = winAddr;
            end else begin
              heldPtrNxt  = pendPtr;
              heldAddrNxt = pendAddr;
            end
          end else if (pendValid) begin
            heldPtrNxt  = pendPtr;
            heldAddrNxt = pendAddr;
          end else if (anyQual) begin
            heldPtrNxt  = winPtr;
            heldAddrNxt = winAddr;
          end else begin
            stateNxt = IDLE;
          end
        end else begin
          doWait = 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
    // Recovery in flight: only mispredicts older than it may be parked
    if (doWait && anyQual) begin
      if (!older(winPtr, refPtr, alHeadPtr)) begin
        dropInc = nQual;
      end else if (!pendValid) begin
        pendValidNxt = 1'b1;
        pendPtrNxt   = winPtr;
        pendAddrNxt  = winAddr;
      end else begin
        dropInc = nQual;
        if (older(winPtr, pendPtr, alHeadPtr)) begin
          pendPtrNxt  = winPtr;
          pendAddrNxt = winAddr;
        end
      end
    end
    dropSum    = {1'b0, dropCnt} + {9'd0, dropInc};
    dropCntNxt = dropSum[16] ? 16'hFFFF : dropSum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      heldPtr   <= '0;
      heldAddr  <= '0;
      flightPtr <= '0;
      pendValid <= 1'b0;
      pendPtr   <= '0;
      pendAddr  <= '0;
      dropCnt   <= '0;
    end else begin
      state     <= stateNxt;
      heldPtr   <= heldPtrNxt;
      heldAddr  <= heldAddrNxt;
      flightPtr <= flightPtrNxt;
      pendValid <= pendValidNxt;
      pendPtr   <= pendPtrNxt;
      pendAddr  <= pendAddrNxt;
      dropCnt   <= dropCntNxt;
    end
  end

  assign recReq  = (state == REQ);
  assign recPtr  = heldPtr;
  assign recAddr = heldAddr;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_int_branch_recovery_arbiter.sv
// Directed bench for int_branch_recovery_arbiter: arbitration, replacement,
// pending slot, pointer wrap, reset and drop-counter saturation.
module tb_int_branch_recovery_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  brValid;
  logic [1:0]  brMispred;
  logic [11:0] brPtr;
  logic [63:0] brNextAddr;
  logic [5:0]  alHeadPtr;
  logic        recAck;
  logic        recDone;
  logic        recReq;
  logic [5:0]  recPtr;
  logic [31:0] recAddr;
  logic        busy;
  logic [15:0] dropCnt;

  int checks = 0;
  int passed = 0;

  int_branch_recovery_arbiter dut (
    .clk(clk), .rst(rst), .brValid(brValid), .brMispred(brMispred),
    .brPtr(brPtr), .brNextAddr(brNextAddr), .alHeadPtr(alHeadPtr),
    .recAck(recAck), .recDone(recDone), .recReq(recReq),
    .recPtr(recPtr), .recAddr(recAddr), .busy(busy), .dropCnt(dropCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int i, input logic [5:0] p,
                         input logic [31:0] a);
    brValid[i]          = 1'b1;
    brMispred[i]        = 1'b1;
    brPtr[i*6 +: 6]     = p;
    brNextAddr[i*32 +: 32] = a;
  endtask

  task automatic clearLanes();
    brValid    = '0;
    brMispred  = '0;
    brPtr      = '0;
    brNextAddr = '0;
  endtask

  task automatic ackDone();
    recAck = 1'b1;
    tick();
    recAck  = 1'b0;
    recDone = 1'b1;
    tick();
    recDone = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearLanes();
    alHeadPtr = '0;
    recAck = 1'b0;
    recDone = 1'b0;
    tick();
    tick();
    checks++;
    if (recReq !== 1'b0 || busy !== 1'b0 || dropCnt !== 16'd0 ||
        recPtr !== 6'd0 || recAddr !== 32'd0)
      $display("FAIL reset_state got req=%b busy=%b drop=%0d ptr=%0d addr=%h exp 0",
               recReq, busy, dropCnt, recPtr, recAddr);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    setLane(0, 6'd5, 32'h1000);
    tick();
    clearLanes();
    checks++;
    if (recReq !== 1'b1 || recPtr !== 6'd5 || recAddr !== 32'h1000)
      $display("FAIL single_req got req=%b ptr=%0d addr=%h exp 1/5/1000",
               recReq, recPtr, recAddr);
    else passed++;
    recAck = 1'b1;
    tick();
    recAck = 1'b0;
    checks++;
    if (recReq !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_wait got req=%b busy=%b exp 0/1", recReq, busy);
    else passed++;
    recAck = 1'b1;
    tick();
    recAck = 1'b0;
    checks++;
    if (recReq !== 1'b0 || busy !== 1'b1)
      $display("FAIL stray_ack got req=%b busy=%b exp 0/1", recReq, busy);
    else passed++;
    recDone = 1'b1;
    tick();
    recDone = 1'b0;
    checks++;
    if (busy !== 1'b0 || recReq !== 1'b0 || dropCnt !== 16'd0)
      $display("FAIL single_done got busy=%b req=%b drop=%0d exp 0/0/0",
               busy, recReq, dropCnt);
    else passed++;
  endtask

  task automatic test_arbitration();
    setLane(0, 6'd9, 32'hA009);
    setLane(1, 6'd4, 32'hA004);
    tick();
    clearLanes();
    checks++;
    if (recPtr !== 6'd4 || recAddr !== 32'hA004 || dropCnt !== 16'd1)
      $display("FAIL arb_oldest got ptr=%0d addr=%h drop=%0d exp 4/a004/1",
               recPtr, recAddr, dropCnt);
    else passed++;
    ackDone();
    setLane(0, 6'd8, 32'hB000);
    setLane(1, 6'd8, 32'hB001);
    tick();
    clearLanes();
    checks++;
    if (recPtr !== 6'd8 || recAddr !== 32'hB000 || dropCnt !== 16'd2)
      $display("FAIL arb_tie got ptr=%0d addr=%h drop=%0d exp 8/b000/2",
               recPtr, recAddr, dropCnt);
    else passed++;
    ackDone();
  endtask

  task automatic test_replace();
    setLane(0, 6'd10, 32'hC010);
    tick();
    setLane(0, 6'd3, 32'hC003);
    tick();
    checks++;
    if (recReq !== 1'b1 || recPtr !== 6'd3 || recAddr !== 32'hC003)
      $display("FAIL replace_older got req=%b ptr=%0d addr=%h exp 1/3/c003",
               recReq, recPtr, recAddr);
    else passed++;
    setLane(0, 6'd20, 32'hC020);
    tick();
    clearLanes();
    checks++;
    if (recPtr !== 6'd3 || dropCnt !== 16'd3)
      $display("FAIL replace_younger got ptr=%0d drop=%0d exp 3/3",
               recPtr, dropCnt);
    else passed++;
    ackDone();
  endtask

  task automatic test_pending();
    setLane(0, 6'd12, 32'hD012);
    tick();
    clearLanes();
    recAck = 1'b1;
    tick();
    recAck = 1'b0;
    setLane(0, 6'd7, 32'hD007);
    tick();
    setLane(0, 6'd15, 32'hD015);
    tick();
    clearLanes();
    checks++;
    if (recReq !== 1'b0 || dropCnt !== 16'd4)
      $display("FAIL pend_drop got req=%b drop=%0d exp 0/4", recReq, dropCnt);
    else passed++;
    recDone = 1'b1;
    tick();
    recDone = 1'b0;
    checks++;
    if (recReq !== 1'b1 || recPtr !== 6'd7 || recAddr !== 32'hD007)
      $display("FAIL pend_req got req=%b ptr=%0d addr=%h exp 1/7/d007",
               recReq, recPtr, recAddr);
    else passed++;
    ackDone();
  endtask

  task automatic test_wrap();
    alHeadPtr = 6'd62;
    setLane(0, 6'd1, 32'hE001);
    setLane(1, 6'd63, 32'hE063);
    tick();
    clearLanes();
    checks++;
    if (recPtr !== 6'd63 || recAddr !== 32'hE063 || dropCnt !== 16'd5)
      $display("FAIL wrap got ptr=%0d addr=%h drop=%0d exp 63/e063/5",
               recPtr, recAddr, dropCnt);
    else passed++;
    ackDone();
    alHeadPtr = 6'd0;
  endtask

  task automatic test_ack_with_cand();
    setLane(0, 6'd10, 32'hF010);
    tick();
    setLane(0, 6'd4, 32'hF004);
    recAck = 1'b1;
    tick();
    recAck = 1'b0;
    clearLanes();
    checks++;
    if (recReq !== 1'b0 || recPtr !== 6'd10 || dropCnt !== 16'd5)
      $display("FAIL ackcand_wait got req=%b ptr=%0d drop=%0d exp 0/10/5",
               recReq, recPtr, dropCnt);
    else passed++;
    recDone = 1'b1;
    tick();
    recDone = 1'b0;
    checks++;
    if (recReq !== 1'b1 || recPtr !== 6'd4 || recAddr !== 32'hF004)
      $display("FAIL ackcand_req got req=%b ptr=%0d addr=%h exp 1/4/f004",
               recReq, recPtr, recAddr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++;
    if (recReq !== 1'b0 || busy !== 1'b0 || dropCnt !== 16'd0 ||
        recPtr !== 6'd0)
      $display("FAIL reset_mid got req=%b busy=%b drop=%0d ptr=%0d exp 0",
               recReq, busy, dropCnt, recPtr);
    else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (recReq !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle got req=%b busy=%b exp 0/0", recReq, busy);
    else passed++;
  endtask

  task automatic test_saturation();
    setLane(0, 6'd0, 32'h5000);
    setLane(1, 6'd0, 32'h5001);
    repeat (1000) tick();
    checks++;
    if (dropCnt !== 16'd1999)
      $display("FAIL sat_partial got %0d exp 1999", dropCnt);
    else passed++;
    repeat (34001) tick();
    checks++;
    if (dropCnt !== 16'hFFFF || recPtr !== 6'd0 || recReq !== 1'b1)
      $display("FAIL sat_full got drop=%h ptr=%0d req=%b exp ffff/0/1",
               dropCnt, recPtr, recReq);
    else passed++;
    clearLanes();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_replace();
    test_pending();
    test_wrap();
    test_ack_with_cand();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
